// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcodes, ALU operations, control bundle,
// immediate formats and small funct-field helpers.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_t;

    typedef struct packed {
        logic reg_wr;
        logic mem_rd;
        logic mem_wr;
        logic branch;
        logic jump;
        logic use_pc;
        logic use_imm;
        logic illegal;
    } ctrl_t;

    // funct3 selects the operation; alt picks SUB/SRA over ADD/SRL.
    function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Register-register ops accept only the base funct7, or the alternate
    // one for SUB and SRA.
    function automatic logic op_funct_ok(input logic [2:0] funct3, input logic [6:0] funct7);
        return (funct7 == FUNCT7_BASE) ||
               ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    endfunction

    // Immediate shifts reuse the upper imm bits as funct7; other OP-IMM
    // encodings carry a plain immediate there and are always legal.
    function automatic logic op_imm_funct_ok(input logic [2:0] funct3, input logic [6:0] funct7);
        logic ok;
        ok = 1'b1;
        if (funct3 == 3'b001) begin
            ok = (funct7 == FUNCT7_BASE);
        end else if (funct3 == 3'b101) begin
            ok = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
        end
        return ok;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: reassembles the I/S/B/U/J immediate fields of an
// RV32I instruction and sign-extends the result to XLEN.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]             instr,
    input  imm_type_t               imm_type,
    output logic signed [XLEN-1:0]  imm
);

    logic signed [31:0] imm32;

    // Gather the scattered immediate bits; bit 31 is always the sign.
    always_comb begin
        imm32 = '0;
        case (imm_type)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: drives register_file read addresses, decodes the
// fetched word and latches operands/immediate/control into the ID/EX
// register. Load-use hazards against the ID/EX load insert a bubble; flush
// kills the ID/EX entry.
// Optional build macro WB_BYPASS_EN: same-cycle writeback data replaces the
// register_file read data for matching source registers.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic [REG_AW-1:0] rf_regA,
    output logic [REG_AW-1:0] rf_regB,
    input  logic [XLEN-1:0]   rf_portA,
    input  logic [XLEN-1:0]   rf_portB,
    input  logic              wb_wr_en,
    input  logic [REG_AW-1:0] wb_regW,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_val,
    output logic [XLEN-1:0]   ex_rs2_val,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rd,
    output alu_op_t           ex_alu_op,
    output ctrl_t             ex_ctrl
);

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign funct3 = if_instr[14:12];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign funct7 = if_instr[31:25];

    assign rf_regA = REG_AW'(rs1);
    assign rf_regB = REG_AW'(rs2);

    ctrl_t                   dec_ctrl;
    alu_op_t                 dec_alu;
    imm_type_t               dec_imm_type;
    logic                    uses_rs1;
    logic                    uses_rs2;
    logic signed [XLEN-1:0]  dec_imm;

    // Classify the fetched word into control bits, ALU op, immediate format
    // and which source registers it really reads.
    always_comb begin
        dec_ctrl     = '0;
        dec_alu      = ALU_ADD;
        dec_imm_type = IMM_NONE;
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec_ctrl.reg_wr  = 1'b1;
                dec_ctrl.use_imm = 1'b1;
                dec_alu          = ALU_PASS_B;
                dec_imm_type     = IMM_U;
            end
            OPC_AUIPC: begin
                dec_ctrl.reg_wr  = 1'b1;
                dec_ctrl.use_pc  = 1'b1;
                dec_ctrl.use_imm = 1'b1;
                dec_imm_type     = IMM_U;
            end
            OPC_JAL: begin
                dec_ctrl.reg_wr  = 1'b1;
                dec_ctrl.jump    = 1'b1;
                dec_ctrl.use_pc  = 1'b1;
                dec_ctrl.use_imm = 1'b1;
                dec_imm_type     = IMM_J;
            end
            OPC_JALR: begin
                dec_ctrl.reg_wr  = 1'b1;
                dec_ctrl.jump    = 1'b1;
                dec_ctrl.use_imm = 1'b1;
                dec_imm_type     = IMM_I;
                uses_rs1         = 1'b1;
            end
            OPC_BRANCH: begin
                dec_ctrl.branch  = 1'b1;
                dec_alu          = ALU_SUB;
                dec_imm_type     = IMM_B;
                uses_rs1         = 1'b1;
                uses_rs2         = 1'b1;
            end
            OPC_LOAD: begin
                dec_ctrl.reg_wr  = 1'b1;
                dec_ctrl.mem_rd  = 1'b1;
                dec_ctrl.use_imm = 1'b1;
                dec_imm_type     = IMM_I;
                uses_rs1         = 1'b1;
            end
            OPC_STORE: begin
                dec_ctrl.mem_wr  = 1'b1;
                dec_ctrl.use_imm = 1'b1;
                dec_imm_type     = IMM_S;
                uses_rs1         = 1'b1;
                uses_rs2         = 1'b1;
            end
            OPC_OP_IMM: begin
                if (op_imm_funct_ok(funct3, funct7)) begin
                    dec_ctrl.reg_wr  = 1'b1;
                    dec_ctrl.use_imm = 1'b1;
                    dec_imm_type     = IMM_I;
                    uses_rs1         = 1'b1;
                    // instr[30] is an immediate bit except for SRAI/SRLI
                    dec_alu = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
                end else begin
                    dec_ctrl.illegal = 1'b1;
                end
            end
            OPC_OP: begin
                if (op_funct_ok(funct3, funct7)) begin
                    dec_ctrl.reg_wr = 1'b1;
                    uses_rs1        = 1'b1;
                    uses_rs2        = 1'b1;
                    dec_alu         = alu_from_funct3(funct3, funct7[5]);
                end else begin
                    dec_ctrl.illegal = 1'b1;
                end
            end
            default: begin
                dec_ctrl.illegal = 1'b1;
            end
        endcase
        // Writes to x0 are discarded architecturally, so never request them.
        if (rd == 5'd0) begin
            dec_ctrl.reg_wr = 1'b0;
        end
    end

    imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .instr    (if_instr[31:7]),
        .imm_type (dec_imm_type),
        .imm      (dec_imm)
    );

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

`ifdef WB_BYPASS_EN
    // register_file writes at the clock edge, so a same-cycle writeback
    // would otherwise be missed by this read.
    assign rs1_val = (wb_wr_en && (wb_regW != '0) && (wb_regW == REG_AW'(rs1))) ? wb_data : rf_portA;
    assign rs2_val = (wb_wr_en && (wb_regW != '0) && (wb_regW == REG_AW'(rs2))) ? wb_data : rf_portB;
`else
    assign rs1_val = rf_portA;
    assign rs2_val = rf_portB;

    logic unused_wb;
    assign unused_wb = ^{wb_wr_en, wb_regW, wb_data};
`endif

    logic                    vld_p1;
    logic [XLEN-1:0]         ex_pc_p1;
    logic [XLEN-1:0]         ex_rs1_val_p1;
    logic [XLEN-1:0]         ex_rs2_val_p1;
    logic signed [XLEN-1:0]  ex_imm_p1;
    logic [REG_AW-1:0]       ex_rd_p1;
    alu_op_t                 ex_alu_op_p1;
    ctrl_t                   ex_ctrl_p1;

    logic id_ex_free;
    logic hz;
    logic take;

    // A load in ID/EX produces its value too late for a dependent reader.
    assign hz = vld_p1 && ex_ctrl_p1.mem_rd && (ex_rd_p1 != '0) &&
                ((uses_rs1 && (REG_AW'(rs1) == ex_rd_p1)) ||
                 (uses_rs2 && (REG_AW'(rs2) == ex_rd_p1)));

    assign id_ex_free = !vld_p1 || ex_ready;
    assign if_ready   = id_ex_free && !hz && !flush;
    assign take       = if_valid && if_ready;

    // ---- stage boundary: decode -> ID/EX register ----
    // Flush wins over everything; otherwise load on transfer, bubble when
    // the slot frees without a transfer, and hold while execute stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1        <= 1'b0;
            ex_pc_p1      <= '0;
            ex_rs1_val_p1 <= '0;
            ex_rs2_val_p1 <= '0;
            ex_imm_p1     <= '0;
            ex_rd_p1      <= '0;
            ex_alu_op_p1  <= ALU_ADD;
            ex_ctrl_p1    <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (id_ex_free) begin
            vld_p1 <= take;
            if (take) begin
                ex_pc_p1      <= if_pc;
                ex_rs1_val_p1 <= rs1_val;
                ex_rs2_val_p1 <= rs2_val;
                ex_imm_p1     <= dec_imm;
                ex_rd_p1      <= REG_AW'(rd);
                ex_alu_op_p1  <= dec_alu;
                ex_ctrl_p1    <= dec_ctrl;
            end
        end
    end

    assign ex_valid   = vld_p1;
    assign ex_pc      = ex_pc_p1;
    assign ex_rs1_val = ex_rs1_val_p1;
    assign ex_rs2_val = ex_rs2_val_p1;
    assign ex_imm     = ex_imm_p1;
    assign ex_rd      = ex_rd_p1;
    assign ex_alu_op  = ex_alu_op_p1;
    assign ex_ctrl    = ex_ctrl_p1;

endmodule
